mem_arbiter: RTL and testbench

Sequential arbiter that shares the single-ported unified RAM between the instruction-fetch and data-access requesters. It sits below the request unit and above the RAM model. It serialises competing requests, holds the RAM strobes stable for the whole access, and returns one-cycle hit pulses with load data. Data has priority, with a starvation guard for fetches and a per-access timeout.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_timeout_ctr.sv | 38 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types and default tuning constants for the memory arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  localparam int DSTREAK_MAX_DEFAULT = 4;
  localparam int TIMEOUT_CYC_DEFAULT = 15;

  // Streak counter is never narrower than 3 bits so small limits still fit.
  function automatic int streak_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  ihit;
  word_t iload;
  logic  dhit;
  word_t dload;
  logic  ierr;
  logic  derr;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ack;

  modport ma (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ack,
    output ihit, iload, dhit, dload, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ram_ack,
    input  ihit, iload, dhit, dload, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Loadable up-counter raising tc while the count equals TC_VAL.
module mem_timeout_ctr #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TC_VAL = '1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority over counting.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Data-priority arbiter sharing one RAM port between fetch and data requesters,
// with a fetch starvation guard and a per-access timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = DSTREAK_MAX_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  ihit,
  output word_t iload,
  output logic  dhit,
  output word_t dload,
  output logic  ierr,
  output logic  derr,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ack
);

  localparam int SW = streak_width(DSTREAK_MAX);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t    state_q,  state_d;
  logic [SW-1:0] streak_q, streak_d;
  word_t         addr_q,   addr_d;
  word_t         store_q,  store_d;
  logic          wr_q,     wr_d;
  logic          ren_q,    ren_d;
  logic          wen_q,    wen_d;

  logic dreq;
  logic streak_ok;
  logic grant_d;
  logic grant_i;
  logic in_acc;
  logic tc;

  assign dreq      = dmemREN | dmemWEN;
  assign streak_ok = (streak_q < SW'(DSTREAK_MAX));
  assign in_acc    = (state_q != IDLE);
  // Data wins unless the streak limit is hit while a fetch waits.
  assign grant_d   = (state_q == IDLE) && dreq && (streak_ok || !imemREN);
  assign grant_i   = (state_q == IDLE) && imemREN && !(dreq && streak_ok);

  // Access-cycle counter: reloaded to 0 while idle, so the first access cycle sees 0.
  mem_timeout_ctr #(
    .WIDTH  (TW),
    .TC_VAL (TW'(TIMEOUT_CYC - 1))
  ) u_timeout (
    .clk      (CLK),
    .srst     (RST),
    .load     (!in_acc),
    .load_val ('0),
    .en       (in_acc),
    .tc       (tc)
  );

  // Next-state, request latching, strobe and streak bookkeeping.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    if (grant_d) begin
      state_d  = DACC;
      addr_d   = dmemaddr;
      store_d  = dmemstore;
      wr_d     = dmemWEN;
      ren_d    = !dmemWEN;
      wen_d    = dmemWEN;
      if (!imemREN) begin
        streak_d = '0;
      end else if (streak_ok) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (grant_i) begin
      state_d  = IACC;
      addr_d   = imemaddr;
      store_d  = '0;
      wr_d     = 1'b0;
      ren_d    = 1'b1;
      wen_d    = 1'b0;
      streak_d = '0;
    end else if (in_acc && (ram_ack || tc)) begin
      state_d = IDLE;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
    end
  end

  // State and latch registers; reset drops any in-flight access silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  // Completion pulses are combinational; an ack on the timeout cycle beats the error.
  assign ihit = (state_q == IACC) && ram_ack;
  assign dhit = (state_q == DACC) && ram_ack;
  assign ierr = (state_q == IACC) && tc && !ram_ack;
  assign derr = (state_q == DACC) && tc && !ram_ack;

  assign iload = ihit ? ramload : '0;
  assign dload = (dhit && !wr_q) ? ramload : '0;

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM responder, queued requesters and a pulse scoreboard.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .DSTREAK_MAX (4),
    .TIMEOUT_CYC (15)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .imemREN   (bus.imemREN),
    .imemaddr  (bus.imemaddr),
    .dmemREN   (bus.dmemREN),
    .dmemWEN   (bus.dmemWEN),
    .dmemaddr  (bus.dmemaddr),
    .dmemstore (bus.dmemstore),
    .ihit      (bus.ihit),
    .iload     (bus.iload),
    .dhit      (bus.dhit),
    .dload     (bus.dload),
    .ierr      (bus.ierr),
    .derr      (bus.derr),
    .ramREN    (bus.ramREN),
    .ramWEN    (bus.ramWEN),
    .ramaddr   (bus.ramaddr),
    .ramstore  (bus.ramstore),
    .ramload   (bus.ramload),
    .ram_ack   (bus.ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;   // {ihit, dhit, ierr, derr}
    word_t      data;
  } exp_t;

  typedef struct {
    logic  wr;
    word_t addr;
    word_t store;
  } dreq_t;

  exp_t  exp_i[$];
  exp_t  exp_d[$];
  word_t ifq[$];
  dreq_t dfq[$];
  word_t mem[word_t];

  int    vectors     = 0;
  int    miscompares = 0;
  int    ack_delay   = 2;
  int    acc_cnt     = 0;
  logic  force_ack   = 1'b0;
  logic  rst_req     = 1'b1;
  logic  i_done      = 1'b0;
  logic  d_done      = 1'b0;
  string ev_log      = "";
  bit    seen_igrant = 1'b0;
  int    nsteps      = 0;

  function automatic word_t memval(input word_t a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string expv);
    vectors++;
    assert (obs == expv) else begin
      miscompares++;
      $error("FAIL %s: observed '%s' expected '%s'", tag, obs, expv);
    end
  endtask

  task automatic push_fetch(input word_t a, input bit err);
    exp_t e;
    ifq.push_back(a);
    e.code = err ? 4'b0010 : 4'b1000;
    e.data = err ? 32'h0 : memval(a);
    exp_i.push_back(e);
  endtask

  task automatic push_data(input bit wr, input word_t a, input word_t s, input bit err, input bit track);
    exp_t  e;
    dreq_t r;
    r.wr = wr; r.addr = a; r.store = s;
    dfq.push_back(r);
    if (track) begin
      e.code = err ? 4'b0001 : 4'b0100;
      e.data = (err || wr) ? 32'h0 : memval(a);
      exp_d.push_back(e);
    end
  endtask

  // One clock cycle: drive RAM and requesters after the edge, check pulses at the falling edge.
  task automatic step();
    exp_t       e;
    logic [3:0] ev;
    @(posedge clk);
    #1;
    rst = rst_req;
    if (bus.ramREN || bus.ramWEN) begin
      acc_cnt++;
      if (ack_delay >= 0 && acc_cnt == ack_delay + 1) begin
        bus.ram_ack = 1'b1;
        if (bus.ramWEN) begin
          mem[bus.ramaddr] = bus.ramstore;
          bus.ramload = 32'hFFFF_FFFF;
        end else begin
          bus.ramload = memval(bus.ramaddr);
        end
      end else begin
        bus.ram_ack = 1'b0;
        bus.ramload = 32'hBAD0_BAD0;
      end
    end else begin
      acc_cnt     = 0;
      bus.ram_ack = 1'b0;
      bus.ramload = 32'hBAD0_BAD0;
    end
    if (force_ack) bus.ram_ack = 1'b1;
    if (i_done && ifq.size() > 0) void'(ifq.pop_front());
    if (d_done && dfq.size() > 0) void'(dfq.pop_front());
    bus.imemREN  = (ifq.size() > 0);
    bus.imemaddr = (ifq.size() > 0) ? ifq[0] : 32'h0;
    if (dfq.size() > 0) begin
      bus.dmemREN   = !dfq[0].wr;
      bus.dmemWEN   = dfq[0].wr;
      bus.dmemaddr  = dfq[0].addr;
      bus.dmemstore = dfq[0].store;
    end else begin
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = 32'h0;
      bus.dmemstore = 32'h0;
    end
    i_done = 1'b0;
    d_done = 1'b0;
    @(negedge clk);
    ev = {bus.ihit, bus.dhit, bus.ierr, bus.derr};
    if (bus.ihit || bus.ierr) begin
      i_done = 1'b1;
      ev_log = {ev_log, "I"};
      if (exp_i.size() == 0) begin
        check("unexpected_i_pulse", 64'(ev), 64'h0);
      end else begin
        e = exp_i.pop_front();
        check("i_pulse", 64'(ev), 64'(e.code));
        check("iload", 64'(bus.iload), 64'(e.data));
      end
    end
    if (bus.dhit || bus.derr) begin
      d_done = 1'b1;
      ev_log = {ev_log, "D"};
      if (exp_d.size() == 0) begin
        check("unexpected_d_pulse", 64'(ev), 64'h0);
      end else begin
        e = exp_d.pop_front();
        check("d_pulse", 64'(ev), 64'(e.code));
        check("dload", 64'(bus.dload), 64'(e.data));
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while ((ifq.size() > 0 || dfq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(ifq.size() + dfq.size()), 64'h0);
  endtask

  initial begin
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemaddr = 32'h0; bus.dmemstore = 32'h0;
    bus.ramload = 32'h0; bus.ram_ack = 1'b0;
    mem[32'h40] = 32'h2402_000A;
    mem[32'h44] = 32'h8C22_0004;
    mem[32'h80] = 32'h0800_0010;

    // Reset state
    rst_req = 1'b1;
    repeat (3) step();
    check("rst_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    check("rst_pulses", 64'({bus.ihit, bus.dhit, bus.ierr, bus.derr}), 64'h0);
    check("rst_ramaddr", 64'(bus.ramaddr), 64'h0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst_req = 1'b0;
    step();

    // Lone fetch, ack two cycles after the strobe
    ack_delay = 2;
    push_fetch(32'h40, 1'b0);
    step();
    check("lf_c0_ramREN", 64'(bus.ramREN), 64'h0);
    step();
    check("lf_c1_ramREN", 64'(bus.ramREN), 64'h1);
    check("lf_c1_ramaddr", 64'(bus.ramaddr), 64'h40);
    step();
    check("lf_c2_ihit", 64'(bus.ihit), 64'h0);
    step();
    check("lf_c3_ihit", 64'(bus.ihit), 64'h1);
    check("lf_c3_iload", 64'(bus.iload), 64'h2402_000A);
    step();
    check("lf_c4_state", 64'(dut.state_q), 64'(IDLE));
    check("lf_c4_ramREN", 64'(bus.ramREN), 64'h0);

    // Simultaneous fetch and data write: data first
    ack_delay = 1;
    ev_log = "";
    push_fetch(32'h44, 1'b0);
    push_data(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step();
    step();
    check("sim_c1_ramWEN", 64'({bus.ramWEN, bus.ramREN}), 64'h2);
    check("sim_c1_ramstore", 64'(bus.ramstore), 64'hDEAD_BEEF);
    check("sim_c1_ramaddr", 64'(bus.ramaddr), 64'h100);
    run("sim_drain", 40);
    check_str("sim_order", ev_log, "DI");
    check("sim_memwrite", 64'(memval(32'h100)), 64'hDEAD_BEEF);

    // Starvation guard: fetch held against six data reads
    ack_delay = 0;
    ev_log = "";
    push_fetch(32'h80, 1'b0);
    for (int i = 0; i < 6; i++) push_data(1'b0, 32'h200 + 32'(4 * i), 32'h0, 1'b0, 1'b1);
    nsteps = 0;
    while ((ifq.size() > 0 || dfq.size() > 0) && nsteps < 200) begin
      step();
      nsteps++;
      if (!seen_igrant && dut.state_q == IACC) begin
        seen_igrant = 1'b1;
        check("starv_streak_igrant", 64'(dut.streak_q), 64'h0);
      end
    end
    check("starv_drain", 64'(ifq.size() + dfq.size()), 64'h0);
    check_str("starv_order", ev_log, "DDDDIDD");
    check("starv_streak_end", 64'(dut.streak_q), 64'h0);

    // Timeout: no ack ever
    ack_delay = -1;
    push_data(1'b0, 32'h300, 32'h0, 1'b1, 1'b1);
    step();
    repeat (14) step();
    check("to_c14_derr", 64'(bus.derr), 64'h0);
    check("to_c14_ramREN", 64'(bus.ramREN), 64'h1);
    step();
    check("to_c15_pulses", 64'({bus.ihit, bus.dhit, bus.ierr, bus.derr}), 64'h1);
    check("to_c15_ramREN", 64'(bus.ramREN), 64'h1);
    step();
    check("to_c16_ramREN", 64'(bus.ramREN), 64'h0);
    check("to_c16_state", 64'(dut.state_q), 64'(IDLE));
    run("to_drain", 10);

    // Ack on exactly the timeout cycle
    ack_delay = 14;
    push_data(1'b0, 32'h304, 32'h0, 1'b0, 1'b1);
    step();
    repeat (15) step();
    check("at_c15_pulses", 64'({bus.dhit, bus.derr}), 64'h2);
    check("at_c15_dload", 64'(bus.dload), 64'hFFFF_FCFB);
    run("at_drain", 10);

    // Reset in the middle of a data access
    ack_delay = -1;
    push_data(1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
    step();
    step();
    step();
    check("rm_in_dacc", 64'(dut.state_q), 64'(DACC));
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    dfq.delete();
    d_done = 1'b0;
    step();
    check("rm_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'h0);
    check("rm_pulses", 64'({bus.ihit, bus.dhit, bus.ierr, bus.derr}), 64'h0);
    check("rm_ram_bus", {bus.ramaddr, bus.ramstore}, 64'h0);
    check("rm_loads", {bus.iload, bus.dload}, 64'h0);
    check("rm_state", 64'(dut.state_q), 64'(IDLE));
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("rm_late_ack", 64'({bus.dhit, bus.derr, bus.ihit}), 64'h0);
    ack_delay = 1;
    ev_log = "";
    push_fetch(32'h44, 1'b0);
    run("rm_fetch_drain", 20);
    check_str("rm_fetch_order", ev_log, "I");

    check("scoreboard_empty", 64'(exp_i.size() + exp_d.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
